// File: rtl/pc_sequencer_pkg.sv
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared definitions for the next-PC generator and fetch
//               sequencer: FSM state encoding, sequential PC increment and
//               the default HALT encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_seq_pkg;

    // Encoding is architecturally visible on o_state.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_STEP_WAIT = 2'd2,
        ST_HALTED    = 2'd3
    } pc_state_e;

    localparam int unsigned PC_INCR            = 4;
    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;

endpackage : pc_seq_pkg

`default_nettype wire

// File: rtl/pc_sequencer_if.sv
// ============================================================================
// Module      : pc_sequencer_if
// Description : Bundle of the sequencer's fetch/control signals.
//               Names are seen from the sequencer: i_* are driven by the PC
//               register, hazard unit, EX branch logic and debug unit; o_*
//               are driven by the sequencer.
//   master : sequencer side (i_* in, o_* out)
//   slave  : environment side (i_* out, o_* in)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] i_PC;
    logic [31:0]       i_instr;
    logic              i_start;
    logic              i_stall;
    logic              i_branch_taken;
    logic [ADDR_W-1:0] i_branch_target;
    logic              i_jump;
    logic [ADDR_W-1:0] i_jump_target;
    logic              i_dbg_step_mode;
    logic              i_dbg_step;

    logic [ADDR_W-1:0] o_PC_next;
    logic              o_PC_write;
    logic [1:0]        o_state;
    logic              o_halted;
    logic [31:0]       o_cycle_count;

    modport master (
        input  i_PC, i_instr, i_start, i_stall, i_branch_taken, i_branch_target,
               i_jump, i_jump_target, i_dbg_step_mode, i_dbg_step,
        output o_PC_next, o_PC_write, o_state, o_halted, o_cycle_count
    );

    modport slave (
        output i_PC, i_instr, i_start, i_stall, i_branch_taken, i_branch_target,
               i_jump, i_jump_target, i_dbg_step_mode, i_dbg_step,
        input  o_PC_next, o_PC_write, o_state, o_halted, o_cycle_count
    );

endinterface : pc_sequencer_if

`default_nettype wire

// File: rtl/pc_sequencer_cycle_counter.sv
// ============================================================================
// Module      : pc_cycle_counter
// Description : Saturating up-counter with enable, asynchronous active-low
//               reset. Only compiled when PC_SEQ_CYCLE_COUNT_EN is defined,
//               since it is only instantiated in that build.
//   clk     in  clock
//   rst     in  asynchronous active-low reset
//   i_en    in  count enable
//   o_count out current count (sticks at all-ones)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef PC_SEQ_CYCLE_COUNT_EN
module pc_cycle_counter #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_en,
    output logic [WIDTH-1:0]      o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_en && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule : pc_cycle_counter
`endif

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : Next-PC generator and fetch sequencer. Writer side of the PC
//               register: sequential increment, branch/jump redirect, hazard
//               stall, HALT detection and debug single-step.
//   clk  in   clock
//   rst  in   asynchronous active-low reset
//   bus  ifc  pc_sequencer_if.master (PC/instr in, control in,
//             o_PC_next/o_PC_write/o_state/o_halted/o_cycle_count out)
// Configuration : PC_SEQ_CYCLE_COUNT_EN builds the RUN-cycle counter;
//                 otherwise o_cycle_count is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = {ADDR_W{1'b0}},
    parameter logic [31:0]     HALT_INSTR   = HALT_INSTR_DEFAULT
) (
    input  wire logic       clk,
    input  wire logic       rst,
    pc_sequencer_if.master  bus
);

    pc_state_e         r_state;
    logic              r_halted;

    logic [ADDR_W-1:0] w_eval_pc;
    logic              w_eval_write;
    logic              w_eval_halt;
    logic              w_advance;
    logic [ADDR_W-1:0] w_pc_next;
    logic              w_pc_write;
    logic [31:0]       w_cycle_count;

    // One fetch-priority evaluation. Redirects come first because any stall
    // or HALT seen this cycle belongs to the wrong path.
    always_comb begin
        w_eval_pc    = bus.i_PC;
        w_eval_write = 1'b1;
        w_eval_halt  = 1'b0;
        if (bus.i_branch_taken) begin
            w_eval_pc = bus.i_branch_target;
        end else if (bus.i_jump) begin
            w_eval_pc = bus.i_jump_target;
        end else if (bus.i_stall) begin
            w_eval_write = 1'b0;
        end else if (bus.i_instr == HALT_INSTR) begin
            w_eval_write = 1'b0;
            w_eval_halt  = 1'b1;
        end else begin
            w_eval_pc = bus.i_PC + ADDR_W'(PC_INCR);
        end
    end

    // w_advance marks cycles that perform an evaluation: every RUN cycle and
    // step-accepted STEP_WAIT cycles. It also drives the cycle counter.
    always_comb begin
        w_pc_next  = bus.i_PC;
        w_pc_write = 1'b0;
        w_advance  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_pc_next  = RESET_VECTOR;
                w_pc_write = 1'b1;
            end
            ST_RUN:       w_advance = 1'b1;
            ST_STEP_WAIT: w_advance = bus.i_dbg_step;
            default:      w_advance = 1'b0;
        endcase
        if (w_advance) begin
            w_pc_next  = w_eval_pc;
            w_pc_write = w_eval_write;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        r_state <= bus.i_dbg_step_mode ? ST_STEP_WAIT : ST_RUN;
                    end
                end
                ST_RUN, ST_STEP_WAIT: begin
                    if (w_advance && w_eval_halt) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= bus.i_dbg_step_mode ? ST_STEP_WAIT : ST_RUN;
                    end
                end
                ST_HALTED: begin
                    r_state  <= ST_HALTED;
                    r_halted <= 1'b1;
                end
            endcase
        end
    end

`ifdef PC_SEQ_CYCLE_COUNT_EN
    pc_cycle_counter #(
        .WIDTH (32)
    ) u_cycle_counter (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_advance),
        .o_count (w_cycle_count)
    );
`else
    assign w_cycle_count = 32'd0;
`endif

    assign bus.o_PC_next     = w_pc_next;
    assign bus.o_PC_write    = w_pc_write;
    assign bus.o_state       = r_state;
    assign bus.o_halted      = r_halted;
    assign bus.o_cycle_count = w_cycle_count;

endmodule : pc_sequencer

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer. The bench plays the PC
//               register, keeps a behavioural model of the sequencer, checks
//               every cycle against it, pins it with hand-computed values and
//               then runs randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pc_sequencer;

    localparam logic [31:0] RV   = 32'h0000_0000;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
`ifdef PC_SEQ_CYCLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_sequencer_if #(.ADDR_W(32)) bus ();

    pc_sequencer #(
        .ADDR_W       (32),
        .RESET_VECTOR (RV),
        .HALT_INSTR   (HALT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    // Model: state number as defined (0 idle,1 run,2 step-wait,3 halted),
    // counter value and the PC register contents.
    int          m_state = 0;
    logic [31:0] m_cnt   = 32'd0;
    logic [31:0] pc      = 32'd0;
    logic [31:0] s_next;
    logic        s_write;

    assign bus.i_PC = pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        bus.i_instr         = 32'h0000_0013;
        bus.i_start         = 1'b0;
        bus.i_stall         = 1'b0;
        bus.i_branch_taken  = 1'b0;
        bus.i_branch_target = 32'd0;
        bus.i_jump          = 1'b0;
        bus.i_jump_target   = 32'd0;
        bus.i_dbg_step      = 1'b0;
    endtask

    // One clock: compare at the falling edge, advance the model at the rising
    // edge, then update the PC register shortly after the edge.
    task automatic tick();
        int          st;
        int          nst;
        logic [31:0] cnt;
        logic [31:0] nx;
        bit          adv;
        bit          wr;
        bit          hlt;
        @(negedge clk);
        st  = rst ? m_state : 0;
        cnt = rst ? m_cnt : 32'd0;
        adv = (st == 1) || (st == 2 && bus.i_dbg_step);
        wr  = (st == 0);
        nx  = RV;
        hlt = 1'b0;
        if (adv) begin
            if (bus.i_branch_taken)       begin wr = 1'b1; nx = bus.i_branch_target; end
            else if (bus.i_jump)          begin wr = 1'b1; nx = bus.i_jump_target; end
            else if (bus.i_stall)         wr = 1'b0;
            else if (bus.i_instr == HALT) begin wr = 1'b0; hlt = 1'b1; end
            else                          begin wr = 1'b1; nx = pc + 32'd4; end
        end
        chk("state", {30'd0, bus.o_state}, st);
        chk("halted", {31'd0, bus.o_halted}, {31'd0, st == 3});
        chk("cycle_count", bus.o_cycle_count, CNT_EN ? cnt : 32'd0);
        chk("pc_write", {31'd0, bus.o_PC_write}, {31'd0, wr});
        if (wr) chk("pc_next", bus.o_PC_next, nx);
        s_next  = bus.o_PC_next;
        s_write = bus.o_PC_write;
        if (st == 0)               nst = bus.i_start ? (bus.i_dbg_step_mode ? 2 : 1) : 0;
        else if (st == 3 || hlt)   nst = 3;
        else                       nst = bus.i_dbg_step_mode ? 2 : 1;
        @(posedge clk);
        if (!rst) begin
            m_state = 0;
            m_cnt   = 32'd0;
        end else begin
            m_state = nst;
            m_cnt   = (adv && cnt != 32'hFFFF_FFFF) ? cnt + 32'd1 : cnt;
        end
        #1;
        if (wr) pc = nx;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must react before any edge.
    task automatic async_reset();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_state", {30'd0, bus.o_state}, 32'd0);
        chk("rst_write", {31'd0, bus.o_PC_write}, 32'd1);
        chk("rst_next", bus.o_PC_next, RV);
        chk("rst_count", bus.o_cycle_count, 32'd0);
        chk("rst_halted", {31'd0, bus.o_halted}, 32'd0);
        m_state = 0;
        m_cnt   = 32'd0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        bus.i_dbg_step_mode = 1'b0;
        async_reset();
        tick();

        // Start and sequential fetch: 0, 4, 8, 12
        bus.i_start = 1'b1;
        tick();
        chk("seq0", s_next, 32'd0);
        bus.i_start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("seq", s_next, 32'd4 * i);
        end
        tick();
        chk("cnt_after_4_run", bus.o_cycle_count, CNT_EN ? 32'd4 : 32'd0);

        // Two stall cycles at 0x10, then 0x14
        bus.i_stall = 1'b1;
        tick(); chk("stall_1_write", {31'd0, s_write}, 32'd0);
        tick(); chk("stall_2_write", {31'd0, s_write}, 32'd0);
        bus.i_stall = 1'b0;
        tick(); chk("after_stall", s_next, 32'h14);

        // Branch beats stall; branch beats jump
        bus.i_stall = 1'b1; bus.i_branch_taken = 1'b1; bus.i_branch_target = 32'h100;
        tick();
        chk("br_over_stall_w", {31'd0, s_write}, 32'd1);
        chk("br_over_stall_pc", s_next, 32'h100);
        clear_inputs();
        bus.i_branch_taken = 1'b1; bus.i_branch_target = 32'h200;
        bus.i_jump = 1'b1; bus.i_jump_target = 32'h300;
        tick();
        chk("br_over_jump", s_next, 32'h200);
        clear_inputs();

        // HALT at 0x20
        bus.i_branch_taken = 1'b1; bus.i_branch_target = 32'h20;
        tick();
        clear_inputs();
        bus.i_instr = HALT;
        tick();
        chk("halt_write", {31'd0, s_write}, 32'd0);
        chk("halted_flag", {31'd0, bus.o_halted}, 32'd1);
        chk("halted_state", {30'd0, bus.o_state}, 32'd3);
        clear_inputs();
        bus.i_start = 1'b1;
        tick(); tick();
        chk("halt_ignores_start", {30'd0, bus.o_state}, 32'd3);
        chk("halt_pc_frozen", pc, 32'h20);
        bus.i_start = 1'b0;
        async_reset();

        // Debug single-step: three pulses five cycles apart
        bus.i_dbg_step_mode = 1'b1;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        chk("step_wait_state", {30'd0, bus.o_state}, 32'd2);
        for (int k = 0; k < 3; k++) begin
            repeat (4) tick();
            chk("step_idle_write", {31'd0, s_write}, 32'd0);
            bus.i_dbg_step = 1'b1;
            tick();
            chk("step_next", s_next, 32'd4 * (k + 1));
            bus.i_dbg_step = 1'b0;
        end
        chk("step_count", bus.o_cycle_count, CNT_EN ? 32'd3 : 32'd0);
        bus.i_dbg_step_mode = 1'b0;
        tick();

        // Wrap-around of the sequential increment, then reset mid-RUN
        bus.i_branch_taken = 1'b1; bus.i_branch_target = 32'hFFFF_FFFC;
        tick();
        clear_inputs();
        tick();
        chk("wrap", s_next, 32'h0000_0000);
        tick();
        async_reset();

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            bus.i_start         = ($urandom_range(0, 3) == 0);
            bus.i_stall         = ($urandom_range(0, 4) == 0);
            bus.i_branch_taken  = ($urandom_range(0, 7) == 0);
            bus.i_jump          = ($urandom_range(0, 7) == 0);
            bus.i_branch_target = $urandom;
            bus.i_jump_target   = $urandom;
            bus.i_instr         = ($urandom_range(0, 19) == 0) ? HALT : $urandom;
            bus.i_dbg_step      = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) bus.i_dbg_step_mode = ~bus.i_dbg_step_mode;
            if ((m_state == 3 && $urandom_range(0, 5) == 0) || $urandom_range(0, 199) == 0)
                async_reset();
            else
                tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pc_sequencer

`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC generator and fetch sequencer. It is the writer side of the `PC` register: it consumes the current `o_PC` value and fetched instruction, and drives the register's `i_PC` and `i_PC_write` inputs. It handles sequential increment, branch/jump redirects, hazard stalls, HALT detection and debug-unit single-step, and sits between the PC register, the hazard unit, the EX-stage branch logic and the debug unit.

## Interface
- `ADDR_W`, 32, PC width
- `RESET_VECTOR`, 32'h0000_0000, PC value driven on the first fetch after start
- `HALT_INSTR`, 32'hFFFF_FFFF, encoding that stops fetch
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `i_PC`  in  ADDR_W  current PC (output of PC register)
- `i_instr`  in  32  instruction fetched at `i_PC`
- `i_start`  in  1  pulse; leaves IDLE
- `i_stall`  in  1  hazard-unit stall request
- `i_branch_taken`  in  1  EX-stage branch resolved taken
- `i_branch_target`  in  ADDR_W  branch destination
- `i_jump`  in  1  ID-stage jump
- `i_jump_target`  in  ADDR_W  jump destination
- `i_dbg_step_mode`  in  1  1 = advance only on `i_dbg_step`
- `i_dbg_step`  in  1  single-cycle step pulse
- `o_PC_next`  out  ADDR_W  value for PC register `i_PC`
- `o_PC_write`  out  1  write enable for PC register
- `o_state`  out  2  current FSM state
- `o_halted`  out  1  high in HALTED
- `o_cycle_count`  out  32  RUN-cycle counter

## Operation
- States: IDLE(0), RUN(1), STEP_WAIT(2), HALTED(3).
- IDLE: `o_PC_write`=1, `o_PC_next`=`RESET_VECTOR` (holds PC at vector). `i_start` moves the FSM to RUN, or to STEP_WAIT if `i_dbg_step_mode`=1.
- RUN, next-PC priority:
  1. `i_branch_taken` → `i_branch_target`
  2. `i_jump` → `i_jump_target`
  3. `i_stall` → no write
  4. `i_instr`==`HALT_INSTR` → no write, go HALTED
  5. otherwise → `i_PC`+4
- A redirect beats a stall and beats a HALT (the HALT sits on the wrong path).
- RUN with `i_dbg_step_mode`=1 → STEP_WAIT at the end of the current cycle.
- STEP_WAIT: `o_PC_write`=0 unless `i_dbg_step`=1. With `i_dbg_step`=1, one RUN-priority evaluation is performed and the FSM stays in STEP_WAIT; if that evaluation hits HALT, the FSM goes HALTED. `i_dbg_step_mode`=0 returns the FSM to RUN.
- HALTED: `o_PC_write`=0, `o_halted`=1. Only `rst` exits.
- Arithmetic: `i_PC`+4 is modulo 2^ADDR_W (0xFFFF_FFFC → 0x0000_0000). Targets pass through unchanged; no alignment check.
- Cycle counter: increments on every clock in RUN and on every step-accepted cycle in STEP_WAIT. Saturates at 0xFFFF_FFFF.

## Timing
- `o_PC_next` and `o_PC_write` are combinational from state and inputs (zero latency). The PC register captures them on the same rising edge.
- State and counter update on the rising `clk` edge.
- Reset (async, any time including mid-RUN): state=IDLE, counter=0, `o_halted`=0. The outputs immediately become `o_PC_write`=1, `o_PC_next`=`RESET_VECTOR`, `o_state`=0.
- `i_start` is ignored outside IDLE. `i_dbg_step` is ignored outside STEP_WAIT.
- Simultaneous `i_branch_taken` and `i_jump`: the branch wins.
- HALT is evaluated on `i_instr` in the same cycle. The PC stays at the HALT address.

## Configuration
- `PC_SEQ_CYCLE_COUNT_EN` defined: the counter is instantiated as described.
- Undefined: the counter is not built and `o_cycle_count` is tied to 0. FSM behaviour is identical.

## Structure
- Shared package `pc_seq_pkg`: state localparams (`ST_IDLE`, `ST_RUN`, `ST_STEP_WAIT`, `ST_HALTED`), `PC_INCR`=4, default `HALT_INSTR`.
- One sub-module, `pc_cycle_counter`: saturating 32-bit counter with enable and async active-low reset. It is instantiated only under `PC_SEQ_CYCLE_COUNT_EN`.

## Test plan
- Reset then `i_start`, with `i_PC` fed back from a PC model → `o_PC_next` sequence 0, 4, 8, 12; `o_PC_write`=1 every cycle; counter=4 after 4 RUN cycles.
- `i_stall`=1 for 2 cycles at PC=0x10 → `o_PC_write`=0 for both cycles, PC stays 0x10, then 0x14.
- `i_stall`=1 together with `i_branch_taken`=1, target 0x100 → `o_PC_write`=1, `o_PC_next`=0x100. Branch and jump asserted together (0x200 vs 0x300) → 0x200.
- `i_instr`=0xFFFF_FFFF at PC=0x20 → `o_halted`=1, `o_state`=3, PC frozen at 0x20. `i_start` is then ignored; `rst`=0 returns to IDLE.
- Step mode: 3 `i_dbg_step` pulses spaced 5 cycles apart from PC=0 → PC 4, 8, 12; writes only on pulse cycles; counter=3.
- PC=0xFFFF_FFFC in RUN → `o_PC_next`=0. Assert `rst` mid-RUN → immediately `o_state`=0, counter=0, `o_PC_next`=`RESET_VECTOR`.
